frogger_input: RTL and testbench

Input conditioning stage that sits directly upstream of the frogger game-logic block. It synchronises and debounces the four raw board push-buttons. It converts each debounced press into a single-cycle active-low move strobe on `up`, `down`, `left` and `right`, with optional auto-repeat while a button is held. Without this stage the game logic would move the frog on every clock while a button is down; with it, the frog moves exactly one square per press.

---
 rtl/frogger_input_if.sv | 24 ++
 rtl/frogger_input.sv | 134 +++++++++++++
 tb/tb_frogger_input.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/frogger_input_if.sv
// Push-button to move-strobe bundle between the board inputs and the input conditioner.
// master drives the raw buttons and observes the strobes.
// slave is the conditioner side.
interface frogger_input_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic [3:0] held;

  modport master (
    output btn_up, btn_down, btn_left, btn_right,
    input  up, down, left, right, held
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right,
    output up, down, left, right, held
  );
endinterface

// File: rtl/frogger_input.sv
// Synchronise and debounce four push-buttons into one-cycle active-low move strobes with auto-repeat.
// Latency: strobe appears DEBOUNCE_CYCLES+2 cycles after a stable press; held follows with the same delay.
// No backpressure: strobes are fire-and-forget, and an opposite pair firing together is dropped.
module frogger_input #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 25_000_000
) (
  input  logic           clk,
  input  logic           reset,
  frogger_input_if.slave bus
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RW   = $clog2(RMAX) + 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [RW-1:0] R_DELAY   = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE    = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] R_ONE     = RW'(1);
  localparam bit            REPEAT_EN = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  // Channel order matches held: 3 = up, 2 = down, 1 = left, 0 = right.
  logic [3:0] btn;
  logic [3:0] fire;
  logic [3:0] level;

  assign btn = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic          sync1;
    logic          s;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt;
    logic          fire_q;

    // Two-flop synchroniser for the asynchronous raw button.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1 <= 1'b0;
        s     <= 1'b0;
      end else begin
        sync1 <= btn[i];
        s     <= sync1;
      end
    end

    // Debounce FSM plus repeat timer; fire_q is a one-cycle registered move request.
    // The repeat timer keeps running through a release bounce so repeat timing is undisturbed.
    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= IDLE;
        cnt    <= '0;
        rcnt   <= '0;
        fire_q <= 1'b0;
      end else begin
        fire_q <= 1'b0;
        case (state)
          IDLE: begin
            if (s) begin
              state <= PRESS_WAIT;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state  <= HELD;
              cnt    <= '0;
              fire_q <= 1'b1;
              rcnt   <= R_DELAY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!s) begin
              state <= RELEASE_WAIT;
              cnt   <= CNT_ONE;
            end else if (REPEAT_EN && rcnt == R_ONE) begin
              fire_q <= 1'b1;
              rcnt   <= R_RATE;
            end
            if (rcnt > R_ONE) rcnt <= rcnt - 1'b1;
          end
          RELEASE_WAIT: begin
            if (s) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
            if (rcnt > R_ONE) rcnt <= rcnt - 1'b1;
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign fire[i]  = fire_q;
    assign level[i] = (state == HELD) || (state == RELEASE_WAIT);
  end

  // Output register: opposite-pair lockout, active-low strobes, debounced levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.up    <= 1'b1;
      bus.down  <= 1'b1;
      bus.left  <= 1'b1;
      bus.right <= 1'b1;
      bus.held  <= 4'b0000;
    end else begin
      bus.up    <= ~(fire[3] & ~fire[2]);
      bus.down  <= ~(fire[2] & ~fire[3]);
      bus.left  <= ~(fire[1] & ~fire[0]);
      bus.right <= ~(fire[0] & ~fire[1]);
      bus.held  <= level;
    end
  end
endmodule

// File: tb/tb_frogger_input.sv
// Bench for frogger_input: directed test-plan scenarios plus random button activity.
// Expected outputs come from a run-length model of the press/release/repeat rules.
// Outputs are compared every cycle on the falling edge.
module tb_frogger_input;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 5;
  localparam logic [7:0] IDLE_OUT = 8'hF0;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  frogger_input_if bus ();

  frogger_input #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: accepted level per channel, consecutive-sample run lengths, repeat timer.
  logic [3:0] ml;
  int         mrun  [4];
  int         mzrun [4];
  int         mrt   [4];
  logic [7:0] pipe  [3];
  logic [7:0] exp_out;
  bit         armed = 0;
  int         cyc   = 0;
  int         base  = 0;
  int         sc    [4];
  int         fe    [4];

  task automatic model_reset();
    ml = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      mrun[c] = 0; mzrun[c] = 0; mrt[c] = 0;
    end
    for (int k = 0; k < 3; k++) pipe[k] = IDLE_OUT;
  endtask

  // One raw button sample per channel; returns {up,down,left,right,held} seen three edges later.
  task automatic model_step(input logic [3:0] b, output logic [7:0] o);
    logic [3:0] f;
    f = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      if (!ml[c]) begin
        mrun[c] = b[c] ? mrun[c] + 1 : 0;
        if (mrun[c] == D) begin
          ml[c] = 1'b1; f[c] = 1'b1; mrt[c] = RD; mrun[c] = 0; mzrun[c] = 0;
        end
      end else if (!b[c]) begin
        mzrun[c]++;
        if (mrt[c] > 1) mrt[c]--;
        if (mzrun[c] == D) begin
          ml[c] = 1'b0; mzrun[c] = 0;
        end
      end else begin
        if (mzrun[c] == 0 && RD != 0 && mrt[c] == 1) begin
          f[c] = 1'b1; mrt[c] = RR;
        end else if (mrt[c] > 1) begin
          mrt[c]--;
        end
        mzrun[c] = 0;
      end
    end
    if (f[3] && f[2]) f[3:2] = 2'b00;
    if (f[1] && f[0]) f[1:0] = 2'b00;
    o = {~f, ml};
  endtask

  task automatic clr_stats();
    base = cyc;
    for (int c = 0; c < 4; c++) begin
      sc[c] = 0; fe[c] = -1;
    end
  endtask

  // Called on a falling edge: compare, drive the next inputs, advance one clock.
  task automatic tick(input logic [3:0] b, input logic r);
    logic [7:0] o;
    o = {bus.up, bus.down, bus.left, bus.right, bus.held};
    if (armed) begin
      check($sformatf("out@%0d", cyc), {24'd0, o}, {24'd0, exp_out});
      for (int c = 0; c < 4; c++) begin
        if (o[4+c] == 1'b0) begin
          if (fe[c] < 0) fe[c] = cyc - 1 - base;
          sc[c]++;
        end
      end
    end
    bus.btn_up    = b[3];
    bus.btn_down  = b[2];
    bus.btn_left  = b[1];
    bus.btn_right = b[0];
    reset         = r;
    @(posedge clk);
    if (r) begin
      model_reset();
      exp_out = IDLE_OUT;
    end else begin
      exp_out = pipe[0];
      pipe[0] = pipe[1];
      pipe[1] = pipe[2];
      model_step(b, pipe[2]);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(4'b0000, 1'b0);
  endtask

  initial begin
    logic [3:0] rb;
    reset = 1'b1;
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    model_reset();
    exp_out = IDLE_OUT;
    @(negedge clk);
    tick(4'b0000, 1'b1);
    armed = 1;
    tick(4'b0000, 1'b1);
    idle(4);

    // Clean press of up for 8 cycles.
    clr_stats();
    for (int k = 0; k < 8; k++) tick(4'b1000, 1'b0);
    idle(12);
    check("clean_up_count", sc[3], 1);
    check("clean_up_edge", fe[3], 6);

    // Bounce on left is rejected.
    clr_stats();
    tick(4'b0010, 1'b0); tick(4'b0000, 1'b0); tick(4'b0010, 1'b0); tick(4'b0000, 1'b0);
    idle(12);
    check("bounce_left_count", sc[1], 0);

    // Auto-repeat on right.
    clr_stats();
    for (int k = 0; k < 27; k++) tick(4'b0001, 1'b0);
    idle(14);
    check("repeat_right_count", sc[0], 4);
    check("repeat_right_first", fe[0], 6);

    // Opposite lockout, then with left added.
    clr_stats();
    for (int k = 0; k < 10; k++) tick(4'b1100, 1'b0);
    idle(12);
    check("lock_ud_count", sc[3] + sc[2], 0);
    clr_stats();
    for (int k = 0; k < 10; k++) tick(4'b1110, 1'b0);
    idle(12);
    check("lock_ud2_count", sc[3] + sc[2], 0);
    check("lock_left_edge", fe[1], 6);

    // Reset two cycles after the down strobe, button kept held.
    for (int k = 0; k < 8; k++) tick(4'b0100, 1'b0);
    clr_stats();
    tick(4'b0100, 1'b1);
    for (int k = 0; k < 12; k++) tick(4'b0100, 1'b0);
    idle(12);
    check("reset_down_count", sc[2], 1);
    check("reset_down_edge", fe[2], 7);

    // Release bounce while held on up.
    clr_stats();
    for (int k = 0; k < 5; k++) tick(4'b1000, 1'b0);
    tick(4'b0000, 1'b0); tick(4'b0000, 1'b0);
    for (int k = 0; k < 15; k++) tick(4'b1000, 1'b0);
    idle(12);
    check("relbounce_up_count", sc[3], 3);

    // Random button activity with occasional resets.
    rb = 4'b0000;
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 5) == 0) rb[c] = ~rb[c];
      tick(rb, ($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0);
    end
    idle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
